// File: rtl/blake2_block_buffer.sv
// Double-buffered BLAKE2s message block collector: bytes fill F, complete blocks move to O
// and wait on a valid/ready handshake. Optional zero padding: BLAKE2_BLOCK_ZERO_PAD_EN.
module blake2_block_buffer #(
  parameter int unsigned BLOCK_BYTES = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       data_v_i,
  input  logic [7:0]                 data_i,
  input  logic [5:0]                 data_idx_i,
  input  logic                       block_first_i,
  input  logic                       block_last_i,
  input  logic [63:0]                ll_i,
  output logic                       blk_v_o,
  input  logic                       blk_ready_i,
  output logic [8*BLOCK_BYTES-1:0]   blk_m_o,
  output logic [63:0]                blk_t_o,
  output logic                       blk_first_o,
  output logic                       blk_last_o,
  output logic                       overflow_o
);

  localparam int unsigned BlockBits = 8 * BLOCK_BYTES;

  // StDone: F just completed, transfer decided on the following edge.
  // StPend: F full and O was busy; F moves once O has drained.
  typedef enum logic [1:0] {StFill, StDone, StPend} f_st_e;

  f_st_e                f_st_q, f_st_d;
  logic [BlockBits-1:0] f_data_q, f_data_d;
  logic                 f_first_q, f_first_d;
  logic                 f_last_q, f_last_d;
  logic [63:0]          f_t_q, f_t_d;
  logic [63:0]          t_q, t_d;

  logic                 o_v_q, o_v_d;
  logic [BlockBits-1:0] o_data_q, o_data_d;
  logic [63:0]          o_t_q, o_t_d;
  logic                 o_first_q, o_first_d;
  logic                 o_last_q, o_last_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic                 o_free;
  logic                 xfer_done;
  logic                 xfer_pend;
  logic                 xfer;
  logic                 blocked;
  logic                 wr;
  logic                 complete;
  logic [63:0]          t_next;

`ifdef BLAKE2_BLOCK_ZERO_PAD_EN
  logic [5:0]           pad_r;
  assign pad_r = ll_i[5:0];
`endif

  always_comb begin
    accept    = o_v_q & blk_ready_i;
    o_free    = ~o_v_q | accept;
    xfer_done = (f_st_q == StDone) & o_free;
    xfer_pend = (f_st_q == StPend) & ~o_v_q;
    xfer      = xfer_done | xfer_pend;
    // A byte may only enter F once the completed block in F is leaving this edge.
    blocked   = (f_st_q == StPend) | ((f_st_q == StDone) & ~o_free);
    wr        = data_v_i & ~blocked;
    complete  = wr & (data_idx_i == 6'(BLOCK_BYTES - 1));
    t_next    = t_q + 64'(BLOCK_BYTES);
  end

  // Fill buffer: byte write, flag accumulation, counter and state.
  always_comb begin
    f_data_d  = f_data_q;
    f_first_d = xfer ? 1'b0 : f_first_q;
    f_last_d  = xfer ? 1'b0 : f_last_q;
    f_t_d     = f_t_q;
    t_d       = t_q;
    f_st_d    = f_st_q;

    if (wr) begin
      f_data_d[8*data_idx_i +: 8] = data_i;
      f_first_d = f_first_d | block_first_i;
      f_last_d  = f_last_d | block_last_i;
      if ((data_idx_i == 6'd0) && block_first_i) begin
        t_d = 64'd0;
      end
    end

    if (complete) begin
      f_t_d = f_last_d ? ll_i : t_next;
      t_d   = t_next;
`ifdef BLAKE2_BLOCK_ZERO_PAD_EN
      if (f_last_d && (pad_r != 6'd0)) begin
        for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
          if (6'(i) >= pad_r) begin
            f_data_d[8*i +: 8] = 8'h00;
          end
        end
      end
`endif
    end

    if (complete) begin
      f_st_d = StDone;
    end else if (xfer) begin
      f_st_d = StFill;
    end else if (f_st_q == StDone) begin
      f_st_d = StPend;
    end
  end

  // Output buffer and sticky overflow.
  always_comb begin
    o_v_d     = o_v_q;
    o_data_d  = o_data_q;
    o_t_d     = o_t_q;
    o_first_d = o_first_q;
    o_last_d  = o_last_q;
    if (xfer) begin
      o_v_d     = 1'b1;
      o_data_d  = f_data_q;
      o_t_d     = f_t_q;
      o_first_d = f_first_q;
      o_last_d  = f_last_q;
    end else if (accept) begin
      o_v_d = 1'b0;
    end
    ovf_d = ovf_q | (data_v_i & blocked);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_st_q    <= StFill;
      f_data_q  <= '0;
      f_first_q <= 1'b0;
      f_last_q  <= 1'b0;
      f_t_q     <= 64'd0;
      t_q       <= 64'd0;
      o_v_q     <= 1'b0;
      o_data_q  <= '0;
      o_t_q     <= 64'd0;
      o_first_q <= 1'b0;
      o_last_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      f_st_q    <= f_st_d;
      f_data_q  <= f_data_d;
      f_first_q <= f_first_d;
      f_last_q  <= f_last_d;
      f_t_q     <= f_t_d;
      t_q       <= t_d;
      o_v_q     <= o_v_d;
      o_data_q  <= o_data_d;
      o_t_q     <= o_t_d;
      o_first_q <= o_first_d;
      o_last_q  <= o_last_d;
      ovf_q     <= ovf_d;
    end
  end

  assign blk_v_o     = o_v_q;
  assign blk_m_o     = o_data_q;
  assign blk_t_o     = o_t_q;
  assign blk_first_o = o_first_q;
  assign blk_last_o  = o_last_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_blake2_block_buffer.sv
// Directed testbench for blake2_block_buffer; honours BLAKE2_BLOCK_ZERO_PAD_EN when defined.
module tb_blake2_block_buffer;

  logic         clk;
  logic         reset;
  logic         data_v_i;
  logic [7:0]   data_i;
  logic [5:0]   data_idx_i;
  logic         block_first_i;
  logic         block_last_i;
  logic [63:0]  ll_i;
  logic         blk_v_o;
  logic         blk_ready_i;
  logic [511:0] blk_m_o;
  logic [63:0]  blk_t_o;
  logic         blk_first_o;
  logic         blk_last_o;
  logic         overflow_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [511:0] cap_m [8];
  logic [63:0]  cap_t [8];
  logic         cap_f [8];
  logic         cap_l [8];
  int           cap_n = 0;

  blake2_block_buffer #(.BLOCK_BYTES(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_v_i     (data_v_i),
    .data_i       (data_i),
    .data_idx_i   (data_idx_i),
    .block_first_i(block_first_i),
    .block_last_i (block_last_i),
    .ll_i         (ll_i),
    .blk_v_o      (blk_v_o),
    .blk_ready_i  (blk_ready_i),
    .blk_m_o      (blk_m_o),
    .blk_t_o      (blk_t_o),
    .blk_first_o  (blk_first_o),
    .blk_last_o   (blk_last_o),
    .overflow_o   (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every block the core accepts on the following rising edge.
  always @(negedge clk) begin
    if (!reset && blk_v_o && blk_ready_i && cap_n < 8) begin
      cap_m[cap_n] = blk_m_o;
      cap_t[cap_n] = blk_t_o;
      cap_f[cap_n] = blk_first_o;
      cap_l[cap_n] = blk_last_o;
      cap_n++;
    end
  end

  function automatic logic [511:0] mk_block(input logic [7:0] base, input logic [7:0] step);
    logic [511:0] m;
    for (int i = 0; i < 64; i++) m[8*i +: 8] = base + 8'(i) * step;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [5:0] idx, input logic [7:0] d, input logic f,
                            input logic l);
    data_v_i      = 1'b1;
    data_i        = d;
    data_idx_i    = idx;
    block_first_i = f;
    block_last_i  = l;
    tick();
    data_v_i      = 1'b0;
  endtask

  task automatic send_block(input logic [7:0] base, input logic [7:0] step, input logic f,
                            input logic l);
    for (int i = 0; i < 64; i++) drive_byte(6'(i), base + 8'(i) * step, f, l);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    data_v_i = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    cap_n = 0;
  endtask

  task automatic test_reset();
    blk_ready_i = 1'b0;
    ll_i = 64'd0;
    do_reset();
    chk_cnt++;
    if ({blk_v_o, blk_first_o, blk_last_o, overflow_o} !== 4'b0000)
      $display("FAIL reset_flags: got v/f/l/ovf=%b want 0000",
               {blk_v_o, blk_first_o, blk_last_o, overflow_o});
    else pass_cnt++;
    chk_cnt++;
    if (blk_m_o !== 512'd0 || blk_t_o !== 64'd0)
      $display("FAIL reset_data: got t=%0d m=%h want 0", blk_t_o, blk_m_o);
    else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    blk_ready_i = 1'b1;
    ll_i = 64'd64;
    send_block(8'h00, 8'h01, 1'b1, 1'b1);
    chk_cnt++;
    if (blk_v_o !== 1'b0) $display("FAIL single_latency_early: got v=%b want 0", blk_v_o);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (blk_v_o !== 1'b1) $display("FAIL single_valid: got v=%b want 1", blk_v_o);
    else pass_cnt++;
    chk_cnt++;
    if (blk_m_o !== mk_block(8'h00, 8'h01))
      $display("FAIL single_data: got %h want %h", blk_m_o, mk_block(8'h00, 8'h01));
    else pass_cnt++;
    chk_cnt++;
    if (blk_t_o !== 64'd64 || blk_first_o !== 1'b1 || blk_last_o !== 1'b1)
      $display("FAIL single_meta: got t=%0d f=%b l=%b want t=64 f=1 l=1",
               blk_t_o, blk_first_o, blk_last_o);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (blk_v_o !== 1'b0) $display("FAIL single_accept: got v=%b want 0", blk_v_o);
    else pass_cnt++;
  endtask

  task automatic test_three_blocks();
    do_reset();
    blk_ready_i = 1'b1;
    ll_i = 64'd150;
    send_block(8'h10, 8'h01, 1'b1, 1'b0);
    send_block(8'h50, 8'h01, 1'b0, 1'b0);
    send_block(8'h90, 8'h01, 1'b0, 1'b1);
    repeat (3) tick();
    chk_cnt++;
    if (cap_n !== 3) $display("FAIL three_count: got %0d blocks want 3", cap_n);
    else pass_cnt++;
    chk_cnt++;
    if (cap_t[0] !== 64'd64 || cap_t[1] !== 64'd128 || cap_t[2] !== 64'd150)
      $display("FAIL three_t: got %0d,%0d,%0d want 64,128,150", cap_t[0], cap_t[1], cap_t[2]);
    else pass_cnt++;
    chk_cnt++;
    if ({cap_f[0], cap_f[1], cap_f[2], cap_l[0], cap_l[1], cap_l[2]} !== 6'b100_001)
      $display("FAIL three_flags: got first/last=%b want 100001",
               {cap_f[0], cap_f[1], cap_f[2], cap_l[0], cap_l[1], cap_l[2]});
    else pass_cnt++;
    chk_cnt++;
    if (cap_m[1] !== mk_block(8'h50, 8'h01))
      $display("FAIL three_data1: got %h want %h", cap_m[1], mk_block(8'h50, 8'h01));
    else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    do_reset();
    blk_ready_i = 1'b0;
    ll_i = 64'd500;
    send_block(8'h00, 8'h01, 1'b1, 1'b0);
    tick();
    send_block(8'h40, 8'h01, 1'b0, 1'b0);
    chk_cnt++;
    if (blk_v_o !== 1'b1 || blk_m_o !== mk_block(8'h00, 8'h01) || blk_t_o !== 64'd64)
      $display("FAIL bp_hold: got v=%b t=%0d m=%h want v=1 t=64 block0", blk_v_o, blk_t_o,
               blk_m_o);
    else pass_cnt++;
    repeat (6) tick();
    blk_ready_i = 1'b1;
    tick();
    blk_ready_i = 1'b0;
    chk_cnt++;
    if (blk_v_o !== 1'b0) $display("FAIL bp_bubble: got v=%b want 0", blk_v_o);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (blk_v_o !== 1'b1 || blk_m_o !== mk_block(8'h40, 8'h01) || blk_t_o !== 64'd128 ||
        blk_first_o !== 1'b0)
      $display("FAIL bp_block1: got v=%b t=%0d f=%b m=%h want v=1 t=128 f=0 block1", blk_v_o,
               blk_t_o, blk_first_o, blk_m_o);
    else pass_cnt++;
    chk_cnt++;
    if (overflow_o !== 1'b0) $display("FAIL bp_overflow: got %b want 0", overflow_o);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    blk_ready_i = 1'b0;
    ll_i = 64'd500;
    send_block(8'h00, 8'h01, 1'b1, 1'b0);
    send_block(8'h40, 8'h01, 1'b0, 1'b0);
    chk_cnt++;
    if (overflow_o !== 1'b0) $display("FAIL ovf_before: got %b want 0", overflow_o);
    else pass_cnt++;
    drive_byte(6'd0, 8'h80, 1'b0, 1'b0);
    chk_cnt++;
    if (overflow_o !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow_o);
    else pass_cnt++;
    for (int i = 1; i < 64; i++) drive_byte(6'(i), 8'h80, 1'b0, 1'b0);
    repeat (3) tick();
    chk_cnt++;
    if (overflow_o !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow_o);
    else pass_cnt++;
    chk_cnt++;
    if (blk_v_o !== 1'b1 || blk_m_o !== mk_block(8'h00, 8'h01) || blk_t_o !== 64'd64)
      $display("FAIL ovf_o_holds: got v=%b t=%0d m=%h want v=1 t=64 block0", blk_v_o, blk_t_o,
               blk_m_o);
    else pass_cnt++;
  endtask

  task automatic test_padding();
    logic [511:0] exp_m;
    do_reset();
    blk_ready_i = 1'b1;
    ll_i = 64'd70;
    send_block(8'h00, 8'h01, 1'b1, 1'b0);
    send_block(8'hFF, 8'h00, 1'b0, 1'b1);
    repeat (3) tick();
`ifdef BLAKE2_BLOCK_ZERO_PAD_EN
    exp_m = '0;
    for (int i = 0; i < 6; i++) exp_m[8*i +: 8] = 8'hFF;
`else
    exp_m = {64{8'hFF}};
`endif
    chk_cnt++;
    if (cap_n !== 2 || cap_m[0] !== mk_block(8'h00, 8'h01))
      $display("FAIL pad_block0: got n=%0d m=%h want n=2 ramp", cap_n, cap_m[0]);
    else pass_cnt++;
    chk_cnt++;
    if (cap_m[1] !== exp_m) $display("FAIL pad_data: got %h want %h", cap_m[1], exp_m);
    else pass_cnt++;
    chk_cnt++;
    if (cap_t[1] !== 64'd70 || cap_l[1] !== 1'b1)
      $display("FAIL pad_t: got t=%0d l=%b want t=70 l=1", cap_t[1], cap_l[1]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    blk_ready_i = 1'b0;
    ll_i = 64'd500;
    send_block(8'h00, 8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) drive_byte(6'(i), 8'hA5, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    chk_cnt++;
    if ({blk_v_o, blk_first_o, blk_last_o, overflow_o} !== 4'b0000 || blk_m_o !== 512'd0 ||
        blk_t_o !== 64'd0)
      $display("FAIL midreset_outputs: got v/f/l/ovf=%b t=%0d want all 0",
               {blk_v_o, blk_first_o, blk_last_o, overflow_o}, blk_t_o);
    else pass_cnt++;
    reset = 1'b0;
    cap_n = 0;
    blk_ready_i = 1'b1;
    send_block(8'h22, 8'h01, 1'b1, 1'b0);
    tick();
    chk_cnt++;
    if (blk_v_o !== 1'b1 || blk_t_o !== 64'd64 || blk_first_o !== 1'b1 ||
        blk_m_o !== mk_block(8'h22, 8'h01))
      $display("FAIL midreset_fresh: got v=%b t=%0d f=%b want v=1 t=64 f=1", blk_v_o, blk_t_o,
               blk_first_o);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    data_v_i = 1'b0;
    data_i = 8'h00;
    data_idx_i = 6'd0;
    block_first_i = 1'b0;
    block_last_i = 1'b0;
    ll_i = 64'd0;
    blk_ready_i = 1'b0;
    test_reset();
    test_single();
    test_three_blocks();
    test_back_pressure();
    test_overflow();
    test_padding();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
